alu_final: RTL and testbench

ALU_FINAL -- requirements
Module: alu_final

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_control.sv | 42 ++++
 rtl/alu_final.sv | 70 +++++++
 tb/tb_alu_final.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice.
// Holds the main-decoder Alu_op encodings, the R-type funct field constants
// and the internal ALU-control enumeration that alu_control produces.
package alu_pkg;

    // Alu_op encodings from the main decoder
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;  // lw/sw/addi
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;  // beq
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;  // decode from funct
    localparam logic [1:0] ALU_OP_SLTI  = 2'b11;  // signed set-less-than

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;

    // Internal ALU operation selected for the datapath
    typedef enum logic [3:0] {
        CtrlAdd,
        CtrlSub,
        CtrlAnd,
        CtrlOr,
        CtrlXor,
        CtrlNor,
        CtrlSlt,
        CtrlSltu,
        CtrlSll,
        CtrlSrl,
        CtrlSra,
        CtrlZero
    } alu_ctrl_e;

endpackage

// File: rtl/alu_control.sv
// ALU control decoder (combinational).
// Ports:
//   alu_op   - in,  2 bits: main-decoder operation class
//   funct    - in,  6 bits: R-type function field (used only for R-type)
//   alu_ctrl - out, alu_ctrl_e: internal operation for the datapath
module alu_control
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_ctrl_e  alu_ctrl
);

    always_comb begin
        alu_ctrl = CtrlZero;
        unique case (alu_op)
            ALU_OP_ADD:  alu_ctrl = CtrlAdd;
            ALU_OP_SUB:  alu_ctrl = CtrlSub;
            ALU_OP_SLTI: alu_ctrl = CtrlSlt;
            ALU_OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD,
                    FUNCT_ADDU: alu_ctrl = CtrlAdd;
                    FUNCT_SUB,
                    FUNCT_SUBU: alu_ctrl = CtrlSub;
                    FUNCT_AND:  alu_ctrl = CtrlAnd;
                    FUNCT_OR:   alu_ctrl = CtrlOr;
                    FUNCT_XOR:  alu_ctrl = CtrlXor;
                    FUNCT_NOR:  alu_ctrl = CtrlNor;
                    FUNCT_SLT:  alu_ctrl = CtrlSlt;
                    FUNCT_SLTU: alu_ctrl = CtrlSltu;
                    FUNCT_SLLV: alu_ctrl = CtrlSll;
                    FUNCT_SRLV: alu_ctrl = CtrlSrl;
                    FUNCT_SRAV: alu_ctrl = CtrlSra;
                    default:    alu_ctrl = CtrlZero;
                endcase
            end
            default: alu_ctrl = CtrlZero;
        endcase
    end

endmodule

// File: rtl/alu_final.sv
// Registered 32-bit MIPS-style ALU.
// One-cycle latency, a new operation accepted every cycle.
// Ports:
//   clk    - in,  1 bit: rising-edge clock
//   reset  - in,  1 bit: synchronous active-high reset
//   a      - in,  32 bits: operand A (rs)
//   b      - in,  32 bits: operand B (rt or immediate)
//   Alu_op - in,  2 bits: main-decoder operation class
//   funct  - in,  6 bits: R-type function field
//   result - out, 32 bits: registered ALU result
//   zero   - out, 1 bit: registered flag, 1 when result is zero
module alu_final
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  Alu_op,
    input  logic [5:0]  funct,
    output logic [31:0] result,
    output logic        zero
);

    alu_ctrl_e   alu_ctrl;
    logic [31:0] result_d;
    logic        zero_d;
    logic [4:0]  shamt;

    alu_control u_alu_control (
        .alu_op   (Alu_op),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

    // Variable shifts take their amount from the low five bits of operand A
    assign shamt = a[4:0];

    always_comb begin
        result_d = 32'h0000_0000;
        case (alu_ctrl)
            CtrlAdd:  result_d = a + b;
            CtrlSub:  result_d = a - b;
            CtrlAnd:  result_d = a & b;
            CtrlOr:   result_d = a | b;
            CtrlXor:  result_d = a ^ b;
            CtrlNor:  result_d = ~(a | b);
            CtrlSlt:  result_d = {31'b0, $signed(a) < $signed(b)};
            CtrlSltu: result_d = {31'b0, a < b};
            CtrlSll:  result_d = b << shamt;
            CtrlSrl:  result_d = b >> shamt;
            CtrlSra:  result_d = $unsigned($signed(b) >>> shamt);
            default:  result_d = 32'h0000_0000;
        endcase
    end

    // Flag derived from the same next-state value so result and zero never skew
    assign zero_d = (result_d == 32'h0000_0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= 32'h0000_0000;
            zero   <= 1'b1;
        end else begin
            result <= result_d;
            zero   <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_final.sv
module tb_alu_final;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  Alu_op;
    logic [5:0]  funct;
    logic [31:0] result;
    logic        zero;

    typedef struct {
        logic [31:0] res;
        logic        z;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    logic issue_flag;
    int   total;
    int   bad;

    alu_final dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .Alu_op (Alu_op),
        .funct  (funct),
        .result (result),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation at the falling edge; expectation goes to the scoreboard
    task automatic issue(input logic rst, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] eres, input logic ez, input string nm);
        exp_t e;
        @(negedge clk);
        reset      = rst;
        Alu_op     = op;
        funct      = fn;
        a          = va;
        b          = vb;
        issue_flag = 1'b1;
        e.res  = eres;
        e.z    = ez;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: one cycle after each issued edge, pop and compare
    initial begin
        logic v;
        exp_t e;
        forever begin
            @(posedge clk);
            v = issue_flag;
            #1;
            if (v) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow: got result=%h, required an entry", result);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (result !== e.res) begin
                        bad++;
                        $display("FAIL %s.result: got %h, required %h", e.name, result, e.res);
                    end
                    total++;
                    if (zero !== e.z) begin
                        bad++;
                        $display("FAIL %s.zero: got %b, required %b", e.name, zero, e.z);
                    end
                end
            end
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        issue_flag = 1'b0;
        reset      = 1'b1;
        a          = '0;
        b          = '0;
        Alu_op     = 2'b00;
        funct      = 6'b0;

        issue(1'b1, 2'b00, 6'b000000, 32'd0, 32'd0, 32'd0, 1'b1, "reset_state");
        issue(1'b0, 2'b00, 6'b100010, 32'd30, 32'd30, 32'd60, 1'b0, "add_funct_ignored");
        issue(1'b0, 2'b01, 6'b000000, 32'd50, 32'd50, 32'd0, 1'b1, "beq_sub");
        issue(1'b0, 2'b10, 6'b100000, 32'd20, 32'd20, 32'd40, 1'b0, "rtype_add");
        issue(1'b0, 2'b10, 6'b100010, 32'd20, 32'd20, 32'd0, 1'b1, "rtype_sub");
        issue(1'b0, 2'b10, 6'b100100, 32'd3, 32'd2, 32'd2, 1'b0, "and");
        issue(1'b0, 2'b10, 6'b100101, 32'd3, 32'd2, 32'd3, 1'b0, "or");
        issue(1'b0, 2'b10, 6'b100110, 32'd3, 32'd2, 32'd1, 1'b0, "xor");
        issue(1'b0, 2'b10, 6'b100111, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, "nor");
        issue(1'b0, 2'b10, 6'b101010, 32'd45, 32'd46, 32'd1, 1'b0, "slt_true");
        issue(1'b0, 2'b10, 6'b101010, 32'd46, 32'd45, 32'd0, 1'b1, "slt_false");
        issue(1'b0, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "slt_neg");
        issue(1'b0, 2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, "sltu_big");
        issue(1'b0, 2'b10, 6'b101010, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, "slt_boundary");
        issue(1'b0, 2'b11, 6'b100000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, "slti");
        issue(1'b0, 2'b11, 6'b000000, 32'd5, 32'hFFFF_FFFB, 32'd0, 1'b1, "slti_false");
        issue(1'b0, 2'b10, 6'b010010, 32'd7, 32'd9, 32'd0, 1'b1, "illegal_funct");
        issue(1'b0, 2'b10, 6'b000100, 32'd4, 32'd1, 32'd16, 1'b0, "sllv");
        issue(1'b0, 2'b10, 6'b000100, 32'd33, 32'd1, 32'd2, 1'b0, "sllv_shamt_mask");
        issue(1'b0, 2'b10, 6'b000110, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0, "srlv");
        issue(1'b0, 2'b10, 6'b000111, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, "srav");
        issue(1'b0, 2'b10, 6'b100001, 32'd1, 32'd1, 32'd2, 1'b0, "addu");
        issue(1'b0, 2'b10, 6'b100011, 32'd5, 32'd3, 32'd2, 1'b0, "subu");
        issue(1'b0, 2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, "add_wrap");
        issue(1'b0, 2'b01, 6'b000000, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, "sub_wrap");
        issue(1'b0, 2'b00, 6'b000000, 32'd7, 32'd8, 32'd15, 1'b0, "pre_reset_add");
        issue(1'b1, 2'b00, 6'b000000, 32'd5, 32'd5, 32'd0, 1'b1, "reset_priority");
        issue(1'b0, 2'b00, 6'b000000, 32'd1, 32'd2, 32'd3, 1'b0, "first_after_reset");

        @(negedge clk);
        issue_flag = 1'b0;
        repeat (3) @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
